// File: rtl/aes_spi_pkg.sv
// Shared types for the AES SPI slave scheduler.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    RECV,
    RESP
  } state_t;

  localparam logic ID_ENC = 1'b0;
  localparam logic ID_DEC = 1'b1;

  function automatic int frame_w(input int nk);
    return 128 + 32 * nk;
  endfunction

endpackage

// File: rtl/aes_spi_shifter.sv
// Parallel-load shift register with a down-counter, reused for TX and RX.
module aes_spi_shifter #(
  parameter int W  = 256,
  parameter int OW = W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [W-1:0]  ld_data,
  input  logic          ld_cnt,
  input  logic [CW-1:0] cnt_val,
  input  logic          shift_en,
  input  logic          cnt_en,
  input  logic          sin,
  output logic [OW-1:0] q,
  output logic          done
);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      if (ld)
        sh <= ld_data;
      else if (shift_en)
        sh <= {sh[W-2:0], sin};
      // Holding at zero keeps the counter from ever wrapping.
      if (ld_cnt)
        cnt <= cnt_val;
      else if (cnt_en && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign q    = sh[W-1 -: OW];
  assign done = (cnt == '0);

endmodule

// File: rtl/aes_spi_sched.sv
// Round-robin SPI scheduler for cipher/inverse-cipher slaves.
// AES_SCHED_FIXED_PRIO_EN: decrypt always wins ties instead of round-robin.
module aes_spi_sched
  import aes_spi_pkg::*;
#(
  parameter int NK         = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enc_valid,
  output logic            enc_ready,
  input  logic [127:0]    enc_data,
  input  logic [32*NK-1:0] enc_key,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [127:0]    dec_data,
  input  logic [32*NK-1:0] dec_key,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [127:0]    rsp_data,
  output logic            spi_cs_enc_n,
  output logic            spi_cs_dec_n,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic            busy
);

  localparam int FW = frame_w(NK);
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] TX_LD  = CW'(FW - 1);
  localparam logic [CW-1:0] RX_LD  = CW'(127);
  localparam logic [CW-1:0] GAP_LD =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic GAP_EN = (GAP_CYCLES != 0);

  state_t          state;
  state_t          state_n;
  logic            id;
  logic            idle;
  logic            grant_dec;
  logic            grant_enc;
  logic            accept;
  logic [FW-1:0]   frame;
  logic            tx_ld_cnt;
  logic [CW-1:0]   tx_cnt_val;
  logic            tx_shift;
  logic            tx_cnt_en;
  logic            tx_q;
  logic            tx_done;
  logic            rx_ld_cnt;
  logic            rx_shift;
  logic [127:0]    rx_q;
  logic            rx_done;
  logic            cs_act;

`ifdef AES_SCHED_FIXED_PRIO_EN
  assign grant_dec = dec_valid;
`else
  logic last_grant;

  assign grant_dec = dec_valid &&
                     (!enc_valid || last_grant == ID_ENC);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= ID_DEC;
    else if (accept)
      last_grant <= grant_dec ? ID_DEC : ID_ENC;
  end
`endif

  assign grant_enc = enc_valid && !grant_dec;
  assign idle      = (state == IDLE);
  assign enc_ready = rst_n && idle && grant_enc;
  assign dec_ready = rst_n && idle && grant_dec;
  assign accept    = enc_ready || dec_ready;
  assign frame     = grant_dec ? {dec_data, dec_key}
                               : {enc_data, enc_key};

  always_comb begin
    state_n    = state;
    tx_ld_cnt  = accept;
    tx_cnt_val = TX_LD;
    rx_ld_cnt  = 1'b0;
    unique case (state)
      IDLE: if (accept) state_n = SEND;
      SEND: begin
        if (tx_done) begin
          if (GAP_EN) begin
            state_n    = GAP;
            tx_ld_cnt  = 1'b1;
            tx_cnt_val = GAP_LD;
          end else begin
            state_n   = RECV;
            rx_ld_cnt = 1'b1;
          end
        end
      end
      GAP: begin
        if (tx_done) begin
          state_n   = RECV;
          rx_ld_cnt = 1'b1;
        end
      end
      RECV: if (rx_done) state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      id        <= ID_ENC;
      rsp_valid <= 1'b0;
      rsp_id    <= ID_ENC;
    end else begin
      state <= state_n;
      if (accept)
        id <= grant_dec ? ID_DEC : ID_ENC;
      if (state == RECV && rx_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign tx_shift  = (state == SEND);
  assign tx_cnt_en = (state == SEND) || (state == GAP);
  assign rx_shift  = (state == RECV);

  // TX shifts in zeros, so its MSB is already 0 outside SEND.
  aes_spi_shifter #(
    .W (FW),
    .OW(1),
    .CW(CW)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (accept),
    .ld_data (frame),
    .ld_cnt  (tx_ld_cnt),
    .cnt_val (tx_cnt_val),
    .shift_en(tx_shift),
    .cnt_en  (tx_cnt_en),
    .sin     (1'b0),
    .q       (tx_q),
    .done    (tx_done)
  );

  aes_spi_shifter #(
    .W (128),
    .OW(128),
    .CW(CW)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (1'b0),
    .ld_data (128'b0),
    .ld_cnt  (rx_ld_cnt),
    .cnt_val (RX_LD),
    .shift_en(rx_shift),
    .cnt_en  (rx_shift),
    .sin     (spi_miso),
    .q       (rx_q),
    .done    (rx_done)
  );

  assign cs_act       = (state == SEND) || (state == GAP) ||
                        (state == RECV);
  assign spi_cs_enc_n = !(cs_act && id == ID_ENC);
  assign spi_cs_dec_n = !(cs_act && id == ID_DEC);
  assign spi_mosi     = tx_q;
  assign rsp_data     = rx_q;
  assign busy         = !idle;

endmodule

// File: tb/tb_aes_spi_sched.sv
// Bench for aes_spi_sched: AES SPI slave models and a scheduler model.
module tb_aes_spi_sched;

  localparam int NK  = 4;
  localparam int GAP = 2;
  localparam int FW  = 128 + 32 * NK;
  localparam int LAT = FW + GAP + 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enc_valid, enc_ready;
  logic [127:0] enc_data, enc_key;
  logic         dec_valid, dec_ready;
  logic [127:0] dec_data, dec_key;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_data;
  logic         spi_cs_enc_n, spi_cs_dec_n;
  logic         spi_mosi, spi_miso;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit lg    = 1'b1;
  bit mon_en = 1'b0;

  logic [7:0] sbox [256];
  logic [7:0] isbox[256];

  always #5 clk = ~clk;

  aes_spi_sched #(.NK(NK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_data(enc_data), .enc_key(enc_key),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_data(dec_data), .dec_key(dec_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .spi_cs_enc_n(spi_cs_enc_n), .spi_cs_dec_n(spi_cs_dec_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      s = s ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_b(input logic [127:0] st,
                                         input bit inv);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox[st[127-8*i -: 8]]
                            : sbox[st[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] st,
                                           input bit inv);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv)
          o[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
        else
          o[127-8*(r+4*((c+r)%4)) -: 8] = st[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] st,
                                         input bit inv);
    logic [127:0] o = '0;
    logic [7:0]   a[4];
    logic [7:0]   cf[4];
    logic [7:0]   v;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = st[127-32*c-8*k -: 8];
      for (int j = 0; j < 4; j++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v = v ^ gm(a[k], cf[(k-j+4)%4]);
        o[127-32*c-8*j -: 8] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] blk,
                                       input logic [127:0] key,
                                       input bit inv);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]],
             sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    if (!inv) begin
      st = blk ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
        st = shift_r(sub_b(st, 1'b0), 1'b0);
        if (r < 10) st = mix_c(st, 1'b0);
        st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
    end else begin
      st = blk ^ {w[40], w[41], w[42], w[43]};
      for (int r = 9; r >= 0; r--) begin
        st = sub_b(shift_r(st, 1'b1), 1'b1);
        st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        if (r > 0) st = mix_c(st, 1'b1);
      end
    end
    return st;
  endfunction

  // SPI slave pair: decodes the frame, answers after the gap.
  int           m = 0;
  logic [FW-1:0] rxf = '0;
  logic [127:0] res = '0;
  bit           sel = 1'b0;

  always @(negedge clk) begin
    if (!spi_cs_enc_n || !spi_cs_dec_n) begin
      m++;
      sel = !spi_cs_dec_n;
      if (m <= FW)
        rxf = {rxf[FW-2:0], spi_mosi};
      else if (m <= FW + GAP)
        chk("gap_mosi", 128'(spi_mosi), 128'd0);
      if (m == FW)
        res = aes(rxf[FW-1 -: 128], rxf[127:0], sel);
      if (m > FW + GAP && m <= FW + GAP + 128)
        spi_miso = res[127 - (m - FW - GAP - 1)];
      else
        spi_miso = 1'b0;
    end else begin
      m = 0;
      spi_miso = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en)
      chk("cs_rule",
          128'({!spi_cs_enc_n && !spi_cs_dec_n,
                (!spi_cs_enc_n || !spi_cs_dec_n) && !busy}),
          128'd0);
  end

  task automatic frame(input bit ev, input bit dv,
                       input logic [127:0] ed, input logic [127:0] ek,
                       input logic [127:0] dd, input logic [127:0] dk,
                       input int stall, input bit hold,
                       output bit gid, output logic [127:0] got);
    bit           w;
    int           n;
    logic [127:0] exp;
    @(negedge clk);
    enc_valid = ev; dec_valid = dv;
    enc_data = ed; enc_key = ek;
    dec_data = dd; dec_key = dk;
    rsp_ready = (stall == 0);
`ifdef AES_SCHED_FIXED_PRIO_EN
    w = dv;
`else
    w = dv && (!ev || lg == 1'b0);
`endif
    #1;
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_rsp", 128'(rsp_valid), 128'd0);
    chk("enc_rdy", 128'(enc_ready), 128'(ev && !w));
    chk("dec_rdy", 128'(dec_ready), 128'(w));
    exp = w ? aes(dd, dk, 1'b1) : aes(ed, ek, 1'b0);
    lg  = w;
    gid = w;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin enc_valid = 1'b0; dec_valid = 1'b0; end
    #1;
    chk("acc_busy", 128'(busy), 128'd1);
    chk("acc_rdy", 128'({enc_ready, dec_ready}), 128'd0);
    n = 1;
    while (!rsp_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n - 1), 128'(LAT));
    chk("rsp_id", 128'(rsp_id), 128'(w));
    chk("rsp_data", rsp_data, exp);
    chk("rsp_cs", 128'({spi_cs_enc_n, spi_cs_dec_n}), 128'd3);
    got = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      enc_valid = 1'b1; dec_valid = 1'b1;
      #1;
      chk("stl_vld", 128'(rsp_valid), 128'd1);
      chk("stl_dat", rsp_data, exp);
      chk("stl_id", 128'(rsp_id), 128'(w));
      chk("stl_rdy", 128'({enc_ready, dec_ready}), 128'd0);
      chk("stl_cs", 128'({spi_cs_enc_n, spi_cs_dec_n}), 128'd3);
    end
    if (stall > 0) begin
      @(negedge clk);
      enc_valid = hold && ev; dec_valid = hold && dv;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
  endtask

  logic [127:0] fkey, fpt, fct, got, rd[4];
  bit           gid, seen;
  bit           ev, dv;
  int           n;

  initial begin
    build_sbox();
    fkey = 128'h000102030405060708090a0b0c0d0e0f;
    fpt  = 128'h00112233445566778899aabbccddeeff;
    fct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    rst_n = 1'b0; rsp_ready = 1'b0;
    enc_valid = 1'b1; dec_valid = 1'b1;
    enc_data = '0; enc_key = '0; dec_data = '0; dec_key = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_cs", 128'({spi_cs_enc_n, spi_cs_dec_n}), 128'd3);
      chk("rst_mosi", 128'(spi_mosi), 128'd0);
      chk("rst_rsp", 128'({rsp_valid, rsp_id}), 128'd0);
      chk("rst_data", rsp_data, 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_rdy", 128'({enc_ready, dec_ready}), 128'd0);
    end
    @(negedge clk);
    enc_valid = 1'b0; dec_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    lg = 1'b1;

    frame(1'b1, 1'b0, fpt, fkey, '0, '0, 0, 1'b0, gid, got);
    chk("fips_enc", got, fct);
    chk("enc_cs_used", 128'(sel), 128'd0);

    frame(1'b0, 1'b1, '0, '0, fct, fkey, 0, 1'b0, gid, got);
    chk("fips_dec", got, fpt);
    chk("dec_cs_used", 128'(sel), 128'd1);

    for (int i = 0; i < 4; i++) rd[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 1'b1, rd[i], rd[(i+1)%4], rd[(i+2)%4], rd[(i+3)%4],
            0, 1'b1, gid, got);
`ifdef AES_SCHED_FIXED_PRIO_EN
      chk("grant_order", 128'(gid), 128'd1);
`else
      chk("grant_order", 128'(gid), 128'(i % 2));
`endif
    end

    frame(1'b1, 1'b1, rd[1], rd[2], rd[3], rd[0], 50, 1'b0, gid, got);
    frame(1'b1, 1'b0, rd[2], rd[0], rd[1], rd[3], 0, 1'b0, gid, got);
    chk("post_stall_id", 128'(gid), 128'd0);

    @(negedge clk);
    enc_valid = 1'b1; enc_data = rd[3]; enc_key = rd[1];
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", 128'({spi_cs_enc_n, spi_cs_dec_n}), 128'd3);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_mosi", 128'(spi_mosi), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lg = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 450) begin
      @(negedge clk);
      seen = seen | rsp_valid | busy;
      n++;
    end
    chk("abort_quiet", 128'(seen), 128'd0);
    frame(1'b1, 1'b1, rd[0], rd[3], rd[2], rd[1], 0, 1'b0, gid, got);
`ifdef AES_SCHED_FIXED_PRIO_EN
    chk("after_rst_id", 128'(gid), 128'd1);
`else
    chk("after_rst_id", 128'(gid), 128'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      ev = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!ev && !dv) ev = 1'b1;
      frame(ev, dv,
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(0, 4)), 1'b0, gid, got);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
